// File: rtl/axi_ram_pkg.sv
// Shared types for the AXI4 slave RAM: burst/response encodings, FSM states and a
// WRAP length legality helper.
package axi_ram_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'd0,
    BurstIncr  = 2'd1,
    BurstWrap  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'd0,
    RespExokay = 2'd1,
    RespSlverr = 2'd2,
    RespDecerr = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } wstate_e;

  typedef enum logic [0:0] {
    RIdle,
    RData
  } rstate_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI4 beat address generator: next beat address plus a per-beat error
// flag covering illegal size, illegal WRAP length and out-of-range addresses.
module axi_burst_addr
  import axi_ram_pkg::*;
#(
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_ADDR_W = 16,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic [AXI_ADDR_W-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [AXI_ADDR_W-1:0] next_addr,
  output logic                  err
);

  localparam int unsigned      ByteW    = $clog2(AXI_DATA_W / 8);
  localparam longint unsigned  MemBytes = 64'(MEM_DEPTH) * 64'(AXI_DATA_W / 8);

  logic [AXI_ADDR_W-1:0] beat_bytes;
  logic [AXI_ADDR_W-1:0] container;
  logic [AXI_ADDR_W-1:0] wrap_mask;

  always_comb begin
    beat_bytes = AXI_ADDR_W'(1) << size;
    container  = (AXI_ADDR_W'(len) + AXI_ADDR_W'(1)) << size;
    wrap_mask  = container - AXI_ADDR_W'(1);
    next_addr  = addr;
    case (burst)
      BurstIncr: next_addr = (addr & ~(beat_bytes - AXI_ADDR_W'(1))) + beat_bytes;
      BurstWrap: next_addr = (addr & ~wrap_mask) | ((addr + beat_bytes) & wrap_mask);
      default:   next_addr = addr;
    endcase
    err = (32'(size) > ByteW) ||
          ((burst == BurstWrap) && !wrap_len_ok(len)) ||
          (64'(addr) >= MemBytes);
  end

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave memory: independent single-outstanding write and read paths with
// FIXED/INCR/WRAP bursts, byte strobes and read-before-write on same-word collisions.
module axi_slave_ram
  import axi_ram_pkg::*;
#(
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_ADDR_W = 16,
  parameter int unsigned AXI_ID_W   = 8,
  parameter int unsigned AXI_USER_W = 1,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    arst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [AXI_ADDR_W-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awlock,
  input  logic [3:0]              awcache,
  input  logic [2:0]              awprot,
  input  logic [3:0]              awqos,
  input  logic [3:0]              awregion,
  input  logic [AXI_ID_W-1:0]     awid,
  input  logic [AXI_USER_W-1:0]   awuser,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic                    wlast,
  input  logic [AXI_DATA_W-1:0]   wdata,
  input  logic [AXI_DATA_W/8-1:0] wstrb,
  input  logic [AXI_USER_W-1:0]   wuser,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [AXI_ID_W-1:0]     bid,
  output logic [1:0]              bresp,
  output logic [AXI_USER_W-1:0]   buser,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [AXI_ADDR_W-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arlock,
  input  logic [3:0]              arcache,
  input  logic [2:0]              arprot,
  input  logic [3:0]              arqos,
  input  logic [3:0]              arregion,
  input  logic [AXI_ID_W-1:0]     arid,
  input  logic [AXI_USER_W-1:0]   aruser,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [AXI_ID_W-1:0]     rid,
  output logic [1:0]              rresp,
  output logic [AXI_DATA_W-1:0]   rdata,
  output logic                    rlast,
  output logic [AXI_USER_W-1:0]   ruser
);

  localparam int unsigned StrbW = AXI_DATA_W / 8;
  localparam int unsigned ByteW = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(MEM_DEPTH);

  logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];

  // Write path
  wstate_e               wstate_q, wstate_d;
  logic [AXI_ADDR_W-1:0] waddr_q, wnext;
  logic [7:0]            wlen_q, wcnt_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;
  logic [AXI_ID_W-1:0]   wid_q;
  logic                  werr_q, wbeat_err, wlast_beat, aw_hs, w_hs;

  assign aw_hs      = awvalid & awready;
  assign w_hs       = wvalid & wready;
  assign wlast_beat = (wcnt_q == wlen_q);

  axi_burst_addr #(
    .AXI_DATA_W(AXI_DATA_W),
    .AXI_ADDR_W(AXI_ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_waddr (
    .addr     (waddr_q),
    .size     (wsize_q),
    .len      (wlen_q),
    .burst    (wburst_q),
    .next_addr(wnext),
    .err      (wbeat_err)
  );

  always_comb begin
    wstate_d = wstate_q;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    unique case (wstate_q)
      WIdle: begin
        awready = 1'b1;
        if (awvalid) wstate_d = WData;
      end
      WData: begin
        wready = 1'b1;
        if (wvalid && wlast_beat) wstate_d = WResp;
      end
      WResp: begin
        bvalid = 1'b1;
        if (bready) wstate_d = WIdle;
      end
      default: wstate_d = WIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wstate_q <= WIdle;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wid_q    <= '0;
      werr_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      if (aw_hs) begin
        waddr_q  <= awaddr;
        wlen_q   <= awlen;
        wsize_q  <= awsize;
        wburst_q <= awburst;
        wid_q    <= awid;
        wcnt_q   <= '0;
        werr_q   <= 1'b0;
      end
      if (w_hs) begin
        waddr_q <= wnext;
        wcnt_q  <= wcnt_q + 8'd1;
        // Length is governed by len; a misplaced wlast only poisons the response.
        if (wbeat_err || (wlast != wlast_beat)) werr_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs && !wbeat_err) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wstrb[b]) mem[waddr_q[ByteW +: IdxW]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign bid   = wid_q;
  assign bresp = werr_q ? RespSlverr : RespOkay;
  assign buser = '0;

  // Read path: the beat register is loaded on the AR handshake and on every
  // non-final R handshake, so beats stream back-to-back.
  rstate_e               rstate_q, rstate_d;
  logic [AXI_ADDR_W-1:0] rnaddr_q, rnext, rld_addr;
  logic [7:0]            rlen_q, rcnt_q, rld_len;
  logic [2:0]            rsize_q, rld_size;
  logic [1:0]            rburst_q, rld_burst, rresp_q;
  logic [AXI_ID_W-1:0]   rid_q;
  logic [AXI_DATA_W-1:0] rdata_q;
  logic                  rlast_q, rbeat_err, ar_hs, r_hs, rload, ridle;

  assign ridle     = (rstate_q == RIdle);
  assign ar_hs     = arvalid & arready;
  assign r_hs      = rvalid & rready;
  assign rload     = ar_hs | (r_hs & ~rlast_q);
  assign rld_addr  = ridle ? araddr  : rnaddr_q;
  assign rld_len   = ridle ? arlen   : rlen_q;
  assign rld_size  = ridle ? arsize  : rsize_q;
  assign rld_burst = ridle ? arburst : rburst_q;

  axi_burst_addr #(
    .AXI_DATA_W(AXI_DATA_W),
    .AXI_ADDR_W(AXI_ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_raddr (
    .addr     (rld_addr),
    .size     (rld_size),
    .len      (rld_len),
    .burst    (rld_burst),
    .next_addr(rnext),
    .err      (rbeat_err)
  );

  always_comb begin
    rstate_d = rstate_q;
    arready  = 1'b0;
    rvalid   = 1'b0;
    unique case (rstate_q)
      RIdle: begin
        arready = 1'b1;
        if (arvalid) rstate_d = RData;
      end
      RData: begin
        rvalid = 1'b1;
        if (rready && rlast_q) rstate_d = RIdle;
      end
      default: rstate_d = RIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      rstate_q <= RIdle;
      rnaddr_q <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      if (ar_hs) begin
        rlen_q   <= arlen;
        rsize_q  <= arsize;
        rburst_q <= arburst;
        rid_q    <= arid;
        rcnt_q   <= '0;
        rlast_q  <= (arlen == 8'd0);
      end else if (r_hs) begin
        if (rlast_q) begin
          rlast_q <= 1'b0;
        end else begin
          rcnt_q  <= rcnt_q + 8'd1;
          rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
        end
      end
      if (rload) begin
        rnaddr_q <= rnext;
        rresp_q  <= rbeat_err ? RespSlverr : RespOkay;
        rdata_q  <= rbeat_err ? '0 : mem[rld_addr[ByteW +: IdxW]];
      end
    end
  end

  assign rid   = rid_q;
  assign rresp = rresp_q;
  assign rdata = rdata_q;
  assign rlast = rlast_q;
  assign ruser = '0;

  logic unused_inputs;
  assign unused_inputs = ^{awlock, awcache, awprot, awqos, awregion, awuser, wuser,
                           arlock, arcache, arprot, arqos, arregion, aruser};

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram: expected B/R responses are queued when stimulus is
// driven and popped when the slave presents them.
module tb_axi_slave_ram;
  import axi_ram_pkg::*;

  localparam int Limit = 40;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } bexp_t;

  logic        aclk, arst;
  logic        awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, awid, arid, bid, rid;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  awcache, awqos, awregion, arcache, arqos, arregion, wstrb;
  logic [0:0]  awuser, wuser, buser, aruser, ruser;
  logic [31:0] wdata, rdata;
  logic        arvalid, arready, arlock, rvalid, rready, rlast;

  rexp_t exp_r[$];
  bexp_t exp_b[$];
  int    vectors = 0;
  int    miscompares = 0;

  axi_slave_ram u_dut (
    .aclk(aclk), .arst(arst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awregion(awregion), .awid(awid), .awuser(awuser),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
    .wuser(wuser),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .buser(buser),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arregion(arregion), .arid(arid), .aruser(aruser),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp), .rdata(rdata),
    .rlast(rlast), .ruser(ruser)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rexp_t mk_r(input logic [7:0] id, input logic [31:0] d,
                                 input logic [1:0] resp, input logic last);
    return rexp_t'{id: id, data: d, resp: resp, last: last};
  endfunction

  function automatic bexp_t mk_b(input logic [7:0] id, input logic [1:0] resp);
    return bexp_t'{id: id, resp: resp};
  endfunction

  task automatic send_aw(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [7:0] id);
    int n;
    awaddr = a; awlen = l; awsize = 3'd2; awburst = b; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < Limit) begin @(posedge aclk); #1; n++; end
    chk("aw_timeout", 64'(n >= Limit), 64'(0));
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    int n;
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    n = 0;
    while (!wready && n < Limit) begin @(posedge aclk); #1; n++; end
    chk("w_timeout", 64'(n >= Limit), 64'(0));
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic recv_b();
    int n;
    bexp_t e;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < Limit) begin @(posedge aclk); #1; n++; end
    chk("b_timeout", 64'(n >= Limit), 64'(0));
    e = exp_b.pop_front();
    chk("b_id", bid, e.id);
    chk("b_resp", bresp, e.resp);
    chk("b_user", buser, 64'(0));
    @(posedge aclk); #1;
    bready = 1'b0;
    chk("awready_after_b", awready, 64'(1));
  endtask

  task automatic send_ar(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [7:0] id);
    int n;
    araddr = a; arlen = l; arsize = 3'd2; arburst = b; arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < Limit) begin @(posedge aclk); #1; n++; end
    chk("ar_timeout", 64'(n >= Limit), 64'(0));
    @(posedge aclk); #1;
    arvalid = 1'b0;
    chk("r_first_latency", rvalid, 64'(1));
  endtask

  // pat gives rready per cycle (bit i%8 on cycle i).
  task automatic recv_r(input int nbeats, input logic [7:0] pat);
    int    got, cyc;
    rexp_t e;
    got = 0; cyc = 0;
    while (got < nbeats && cyc < Limit) begin
      rready = pat[cyc % 8];
      if (rvalid) begin
        e = exp_r[0];
        chk("r_data", rdata, e.data);
        chk("r_resp", rresp, e.resp);
        chk("r_last", rlast, e.last);
        chk("r_id", rid, e.id);
        if (rready) begin
          void'(exp_r.pop_front());
          got++;
        end
      end
      @(posedge aclk); #1;
      cyc++;
    end
    rready = 1'b0;
    chk("r_timeout", 64'(cyc >= Limit), 64'(0));
    chk("r_idle_after_burst", rvalid, 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, awready, 64'(1));
    chk({tag, "_arready"}, arready, 64'(1));
    chk({tag, "_wready"}, wready, 64'(0));
    chk({tag, "_bvalid"}, bvalid, 64'(0));
    chk({tag, "_rvalid"}, rvalid, 64'(0));
    chk({tag, "_rlast"}, rlast, 64'(0));
    chk({tag, "_bresp"}, bresp, 64'(0));
    chk({tag, "_rresp"}, rresp, 64'(0));
    chk({tag, "_bid"}, bid, 64'(0));
    chk({tag, "_rid"}, rid, 64'(0));
    chk({tag, "_rdata"}, rdata, 64'(0));
    chk({tag, "_users"}, {buser, ruser}, 64'(0));
  endtask

  initial begin
    arst = 1'b1;
    awvalid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 0; awlock = 0;
    awcache = 0; awprot = 0; awqos = 0; awregion = 0; awid = 0; awuser = 0;
    wvalid = 0; wlast = 0; wdata = 0; wstrb = 0; wuser = 0; bready = 0;
    arvalid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 0; arlock = 0;
    arcache = 0; arprot = 0; arqos = 0; arregion = 0; arid = 0; aruser = 0; rready = 0;
    repeat (2) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    arst = 1'b0;
    @(posedge aclk); #1;

    // INCR write then read-back
    send_aw(16'h0010, 8'd3, BurstIncr, 8'h5A);
    exp_b.push_back(mk_b(8'h5A, RespOkay));
    for (int i = 0; i < 4; i++) send_w(32'hA0 + i, 4'hF, i == 3);
    recv_b();
    for (int i = 0; i < 4; i++) exp_r.push_back(mk_r(8'h33, 32'hA0 + i, RespOkay, i == 3));
    send_ar(16'h0010, 8'd3, BurstIncr, 8'h33);
    recv_r(4, 8'hFF);

    // Byte strobes
    send_aw(16'h0040, 8'd0, BurstIncr, 8'h11);
    exp_b.push_back(mk_b(8'h11, RespOkay));
    send_w(32'hDEADBEEF, 4'hF, 1'b1);
    recv_b();
    send_aw(16'h0040, 8'd0, BurstIncr, 8'h12);
    exp_b.push_back(mk_b(8'h12, RespOkay));
    send_w(32'h11223344, 4'h5, 1'b1);
    recv_b();
    exp_r.push_back(mk_r(8'h34, 32'hDE22BE44, RespOkay, 1'b1));
    send_ar(16'h0040, 8'd0, BurstIncr, 8'h34);
    recv_r(1, 8'hFF);

    // WRAP: fill 0x30..0x3C, then wrap-read from 0x38
    send_aw(16'h0030, 8'd3, BurstIncr, 8'h13);
    exp_b.push_back(mk_b(8'h13, RespOkay));
    for (int i = 0; i < 4; i++) send_w(32'hC0 + i, 4'hF, i == 3);
    recv_b();
    exp_r.push_back(mk_r(8'h35, 32'hC2, RespOkay, 1'b0));
    exp_r.push_back(mk_r(8'h35, 32'hC3, RespOkay, 1'b0));
    exp_r.push_back(mk_r(8'h35, 32'hC0, RespOkay, 1'b0));
    exp_r.push_back(mk_r(8'h35, 32'hC1, RespOkay, 1'b1));
    send_ar(16'h0038, 8'd3, BurstWrap, 8'h35);
    recv_r(4, 8'hFF);
    for (int i = 0; i < 3; i++) exp_r.push_back(mk_r(8'h36, 32'h0, RespSlverr, i == 2));
    send_ar(16'h0030, 8'd2, BurstWrap, 8'h36);
    recv_r(3, 8'hFF);

    // R backpressure: rready 1,0,0,1
    exp_r.push_back(mk_r(8'h37, 32'hA0, RespOkay, 1'b0));
    exp_r.push_back(mk_r(8'h37, 32'hA1, RespOkay, 1'b1));
    send_ar(16'h0010, 8'd1, BurstIncr, 8'h37);
    recv_r(2, 8'b1111_1001);

    // B backpressure: bready low for 5 cycles
    send_aw(16'h0020, 8'd0, BurstIncr, 8'h14);
    exp_b.push_back(mk_b(8'h14, RespOkay));
    send_w(32'h55, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("b_hold_bvalid", bvalid, 64'(1));
      chk("b_hold_awready", awready, 64'(0));
      chk("b_hold_bid", bid, 64'h14);
      @(posedge aclk); #1;
    end
    recv_b();

    // wlast early then missing: length follows len, data lands, response SLVERR
    send_aw(16'h0050, 8'd1, BurstIncr, 8'h15);
    exp_b.push_back(mk_b(8'h15, RespSlverr));
    send_w(32'h5, 4'hF, 1'b1);
    send_w(32'h6, 4'hF, 1'b0);
    recv_b();
    exp_r.push_back(mk_r(8'h38, 32'h5, RespOkay, 1'b0));
    exp_r.push_back(mk_r(8'h38, 32'h6, RespOkay, 1'b1));
    send_ar(16'h0050, 8'd1, BurstIncr, 8'h38);
    recv_r(2, 8'hFF);

    // Out of range write aliasing word 0, with a concurrent AR
    send_aw(16'h0000, 8'd0, BurstIncr, 8'h16);
    exp_b.push_back(mk_b(8'h16, RespOkay));
    send_w(32'h0BADF00D, 4'hF, 1'b1);
    recv_b();
    awaddr = 16'h1000; awlen = 8'd0; awburst = BurstIncr; awid = 8'h21; awvalid = 1'b1;
    araddr = 16'h0010; arlen = 8'd0; arburst = BurstIncr; arid = 8'h22; arvalid = 1'b1;
    chk("aw_ar_both_ready", {awready, arready}, 64'h3);
    @(posedge aclk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    chk("concurrent_rvalid", rvalid, 64'(1));
    chk("concurrent_wready", wready, 64'(1));
    exp_r.push_back(mk_r(8'h22, 32'hA0, RespOkay, 1'b1));
    recv_r(1, 8'hFF);
    exp_b.push_back(mk_b(8'h21, RespSlverr));
    send_w(32'h99, 4'hF, 1'b1);
    recv_b();
    exp_r.push_back(mk_r(8'h39, 32'h0BADF00D, RespOkay, 1'b1));
    send_ar(16'h0000, 8'd0, BurstIncr, 8'h39);
    recv_r(1, 8'hFF);

    // Reset in the middle of a len=7 write
    send_aw(16'h0060, 8'd7, BurstIncr, 8'h44);
    send_w(32'hE0, 4'hF, 1'b0);
    send_w(32'hE1, 4'hF, 1'b0);
    arst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge aclk); #1;
    arst = 1'b0;
    @(posedge aclk); #1;
    send_aw(16'h0064, 8'd0, BurstIncr, 8'h45);
    exp_b.push_back(mk_b(8'h45, RespOkay));
    send_w(32'h77, 4'hF, 1'b1);
    recv_b();
    exp_r.push_back(mk_r(8'h3A, 32'hE0, RespOkay, 1'b0));
    exp_r.push_back(mk_r(8'h3A, 32'h77, RespOkay, 1'b1));
    send_ar(16'h0060, 8'd1, BurstIncr, 8'h3A);
    recv_r(2, 8'hFF);

    chk("scoreboard_drained", 64'(exp_r.size() + exp_b.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
